imem_port_ctrl: RTL

- Sequences and shares the byte-wide, single-port instruction memory between two requesters: core fetch (32-bit word read) and program loader (byte write).
- Fetch words are assembled big-endian: the byte at addr lands in [31:24] and addr+3 lands in [7:0], matching the core's existing instruction byte order.
- Sits between the fetch stage / boot loader and the instruction memory macro; the memory has a synchronous 1-cycle read.

---
 rtl/imem_port_ctrl_pkg.sv | 23 ++
 rtl/imem_port_ctrl_if.sv | 41 ++++
 rtl/imem_port_ctrl_rr_arbiter.sv | 48 ++++
 rtl/imem_port_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/imem_port_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// imem_ctrl_pkg
// Shared types and constants for the instruction-memory port controller:
// FSM state encoding, arbiter grant encoding, instruction size in bytes and
// the default NOP returned on a fetch error.
// ---------------------------------------------------------------------------
package imem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE
    } state_t;

    typedef enum logic {
        GNT_FETCH,
        GNT_LOAD
    } grant_t;

    localparam int          BYTES_PER_INSN = 4;
    localparam logic [31:0] NOP_DEFAULT    = 32'h00000013;

endpackage

// File: rtl/imem_port_ctrl_if.sv
// ---------------------------------------------------------------------------
// imem_port_ctrl_if
// Bundles the fetch request/response, loader write and memory-macro signals
// of the instruction-memory port controller.
//   slave  : controller view (takes requests, drives memory side)
//   master : environment view (fetch stage, loader and memory macro)
// Parameter ADDR_W : memory address width.
// ---------------------------------------------------------------------------
interface imem_port_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              fetch_req_valid;
    logic [31:0]       fetch_req_addr;
    logic              fetch_req_ready;
    logic              fetch_rsp_valid;
    logic [31:0]       fetch_rsp_instr;
    logic              fetch_rsp_err;

    logic              load_valid;
    logic [31:0]       load_addr;
    logic [7:0]        load_data;
    logic              load_ready;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  fetch_req_valid, fetch_req_addr, load_valid, load_addr, load_data, mem_rdata,
        output fetch_req_ready, fetch_rsp_valid, fetch_rsp_instr, fetch_rsp_err,
               load_ready, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output fetch_req_valid, fetch_req_addr, load_valid, load_addr, load_data, mem_rdata,
        input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_instr, fetch_rsp_err,
               load_ready, mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/imem_port_ctrl_rr_arbiter.sv
// ---------------------------------------------------------------------------
// imem_rr_arbiter
// Two-way round-robin arbiter between core fetch and program loader.
// On a tie the requester that was not granted last wins; last_grant resets
// to GNT_LOAD so fetch wins the first tie.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   en                   : grants only issued while high
//   req_fetch, req_load  : request inputs
//   gnt_fetch, gnt_load  : one-hot (or zero) combinational grants
// ---------------------------------------------------------------------------
module imem_rr_arbiter
    import imem_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_fetch,
    input  logic req_load,
    output logic gnt_fetch,
    output logic gnt_load
);

    grant_t last_grant;

    always_comb begin
        gnt_fetch = 1'b0;
        gnt_load  = 1'b0;
        if (en) begin
            if (req_fetch && (!req_load || last_grant == GNT_LOAD)) begin
                gnt_fetch = 1'b1;
            end else if (req_load) begin
                gnt_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GNT_LOAD;
        end else if (gnt_fetch) begin
            last_grant <= GNT_FETCH;
        end else if (gnt_load) begin
            last_grant <= GNT_LOAD;
        end
    end

endmodule

// File: rtl/imem_port_ctrl.sv
// ---------------------------------------------------------------------------
// imem_port_ctrl
// Shares a byte-wide, single-port instruction memory (1-cycle synchronous
// read) between core fetch (32-bit big-endian word read, 4 byte beats) and
// the program loader (single byte write).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : fetch request/response, loader write, memory macro side
//   load_locked  : only with IMEM_LOAD_LOCK_EN; set by the first accepted
//                  in-range fetch, blocks loader writes until reset
// Optional feature macro: IMEM_LOAD_LOCK_EN
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | arbitrate; error fetches answered next cycle without leaving IDLE
// FETCH | issuing byte reads addr+0..addr+3, shifting returned bytes in
// WRITE | single cycle with the (possibly suppressed) write on the bus
// ---------------------------------------------------------------------------
module imem_port_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int          DEPTH    = 1024,
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] NOP_INSN = NOP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    imem_port_ctrl_if.slave  bus
`ifdef IMEM_LOAD_LOCK_EN
    ,
    output logic             load_locked
`endif
);

    localparam logic [1:0]  LAST_BEAT = 2'(BYTES_PER_INSN - 1);
    localparam logic [32:0] DEPTH_33  = 33'(DEPTH);
    localparam logic [31:0] DEPTH_32  = 32'(DEPTH);

    state_t            state, state_d;
    logic [1:0]        beat, beat_d;
    logic [23:0]       asm_q, asm_d;
    logic [31:0]       instr_q, instr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_from_mem_q, rsp_from_mem_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;

    logic gnt_fetch, gnt_load;
    logic fetch_oob, load_oob;
    logic write_blocked;
    logic [31:0] mem_instr;

    imem_rr_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (state == IDLE),
        .req_fetch (bus.fetch_req_valid),
        .req_load  (bus.load_valid),
        .gnt_fetch (gnt_fetch),
        .gnt_load  (gnt_load)
    );

    // 33-bit check so addresses near 2^32 cannot wrap into range.
    assign fetch_oob = ({1'b0, bus.fetch_req_addr} + 33'd3) >= DEPTH_33;
    assign load_oob  = bus.load_addr >= DEPTH_32;

    // Last byte arrives in the response cycle itself, so it is spliced in
    // combinationally rather than costing another cycle of latency.
    assign mem_instr = {asm_q, bus.mem_rdata};

    always_comb begin
        state_d        = state;
        beat_d         = beat;
        asm_d          = asm_q;
        instr_d        = instr_q;
        rsp_valid_d    = 1'b0;
        rsp_err_d      = rsp_err_q;
        rsp_from_mem_d = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_we_d       = 1'b0;
        mem_wdata_d    = mem_wdata_q;

        if (rsp_from_mem_q) begin
            instr_d = mem_instr;
        end

        case (state)
            IDLE: begin
                if (gnt_fetch) begin
                    if (fetch_oob) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        instr_d     = NOP_INSN;
                    end else begin
                        state_d    = FETCH;
                        beat_d     = '0;
                        mem_addr_d = bus.fetch_req_addr[ADDR_W-1:0];
                    end
                end else if (gnt_load) begin
                    state_d     = WRITE;
                    mem_addr_d  = bus.load_addr[ADDR_W-1:0];
                    mem_wdata_d = bus.load_data;
                    mem_we_d    = !load_oob && !write_blocked;
                end
            end
            FETCH: begin
                // Beat 0 has no data back yet; beats 1..3 capture bytes 0..2.
                if (beat != 2'd0) begin
                    asm_d = {asm_q[15:0], bus.mem_rdata};
                end
                if (beat == LAST_BEAT) begin
                    state_d        = IDLE;
                    rsp_valid_d    = 1'b1;
                    rsp_err_d      = 1'b0;
                    rsp_from_mem_d = 1'b1;
                end else begin
                    beat_d     = beat + 2'd1;
                    mem_addr_d = mem_addr_q + 1'b1;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            beat           <= '0;
            asm_q          <= '0;
            instr_q        <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_err_q      <= 1'b0;
            rsp_from_mem_q <= 1'b0;
            mem_addr_q     <= '0;
            mem_we_q       <= 1'b0;
            mem_wdata_q    <= '0;
        end else begin
            state          <= state_d;
            beat           <= beat_d;
            asm_q          <= asm_d;
            instr_q        <= instr_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_err_q      <= rsp_err_d;
            rsp_from_mem_q <= rsp_from_mem_d;
            mem_addr_q     <= mem_addr_d;
            mem_we_q       <= mem_we_d;
            mem_wdata_q    <= mem_wdata_d;
        end
    end

`ifdef IMEM_LOAD_LOCK_EN
    logic lock_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= 1'b0;
        end else if (gnt_fetch && !fetch_oob) begin
            lock_q <= 1'b1;
        end
    end

    assign write_blocked = lock_q;
    assign load_locked   = lock_q;
`else
    assign write_blocked = 1'b0;
`endif

    assign bus.fetch_req_ready = gnt_fetch;
    assign bus.load_ready      = gnt_load;
    assign bus.fetch_rsp_valid = rsp_valid_q;
    assign bus.fetch_rsp_err   = rsp_err_q;
    assign bus.fetch_rsp_instr = rsp_from_mem_q ? mem_instr : instr_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_we          = mem_we_q;
    assign bus.mem_wdata       = mem_wdata_q;

endmodule
